// File: rtl/axis_step_seeker.sv
// axis_step_seeker: single-axis step/direction seeker with soft-limit clamp and switch homing.
// Define AXIS_RAMP_EN to compile in the linear acceleration/deceleration ramp.
module axis_step_seeker #(
  parameter int POS_W      = 19,
  parameter int DIV_W      = 16,
  parameter int STEP_DIV   = 4,
  parameter int HOME_DIV   = 8,
  parameter int RAMP_START = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [POS_W-1:0] Target,
  input  logic [POS_W-1:0] Limit,
  input  logic             Home,
  input  logic             LS,
  input  logic             Abort,
  output logic [POS_W-1:0] Location,
  output logic             CW,
  output logic             CCW,
  output logic             Busy,
  output logic             Done,
  output logic             Clamped,
  output logic             Err,
  output logic             Homed
);

`ifdef AXIS_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif
  localparam logic [DIV_W-1:0] START_HALF = RAMP_ON ? DIV_W'(RAMP_START) : DIV_W'(STEP_DIV);
  localparam logic [DIV_W-1:0] HOME_HALF  = DIV_W'(HOME_DIV);

  typedef enum logic [2:0] {IDLE, MOVE_LO, MOVE_HI, HOME_LO, HOME_HI} state_t;

  state_t           state, state_nx;
  logic             ls_meta, ls_s;
  logic [DIV_W-1:0] cnt, cnt_nx, half, half_nx, phase_len;
  logic [POS_W-1:0] goal, goal_nx, loc_nx, clip;
  logic             dir, dir_nx, clamp, clamp_nx, over, phase_end;
  logic             cw_nx, ccw_nx, busy_nx, done_nx, clamped_nx, err_nx, homed_nx;
`ifdef AXIS_RAMP_EN
  logic [POS_W-1:0] rem;
  assign rem = dir ? (goal - Location) : (Location - goal);
`endif

  assign over      = Target > Limit;
  assign clip      = over ? Limit : Target;
  assign phase_len = ((state == HOME_LO) || (state == HOME_HI)) ? HOME_HALF : half;
  assign phase_end = (cnt == (phase_len - DIV_W'(1)));

  // Home switch is asynchronous: two-flop synchroniser before use.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ls_meta <= 1'b0;
      ls_s    <= 1'b0;
    end else begin
      ls_meta <= LS;
      ls_s    <= ls_meta;
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      half     <= START_HALF;
      goal     <= '0;
      dir      <= 1'b0;
      clamp    <= 1'b0;
      Location <= '0;
      CW       <= 1'b0;
      CCW      <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Clamped  <= 1'b0;
      Err      <= 1'b0;
      Homed    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      half     <= half_nx;
      goal     <= goal_nx;
      dir      <= dir_nx;
      clamp    <= clamp_nx;
      Location <= loc_nx;
      CW       <= cw_nx;
      CCW      <= ccw_nx;
      Busy     <= busy_nx;
      Done     <= done_nx;
      Clamped  <= clamped_nx;
      Err      <= err_nx;
      Homed    <= homed_nx;
    end
  end

  // Next-state and next-output logic; Abort overrides every state.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + DIV_W'(1);
    half_nx    = half;
    goal_nx    = goal;
    dir_nx     = dir;
    clamp_nx   = clamp;
    loc_nx     = Location;
    cw_nx      = CW;
    ccw_nx     = CCW;
    busy_nx    = Busy;
    done_nx    = 1'b0;
    clamped_nx = 1'b0;
    err_nx     = 1'b0;
    homed_nx   = Homed;
    if (Abort) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      cw_nx    = 1'b0;
      ccw_nx   = 1'b0;
      busy_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx = '0;
          if (Home) begin
            busy_nx  = 1'b1;
            homed_nx = 1'b0;
            state_nx = HOME_LO;
          end else if (Start && !Homed) begin
            err_nx = 1'b1;
          end else if (Start && (clip == Location)) begin
            done_nx    = 1'b1;
            clamped_nx = over;
          end else if (Start) begin
            goal_nx  = clip;
            clamp_nx = over;
            dir_nx   = clip > Location;
            half_nx  = START_HALF;
            busy_nx  = 1'b1;
            state_nx = MOVE_LO;
          end else begin
            state_nx = IDLE;
          end
        end
        MOVE_LO: begin
          if (phase_end) begin
            cnt_nx   = '0;
            cw_nx    = dir;
            ccw_nx   = !dir;
            loc_nx   = dir ? (Location + POS_W'(1)) : (Location - POS_W'(1));
            state_nx = MOVE_HI;
          end else begin
            state_nx = MOVE_LO;
          end
        end
        MOVE_HI: begin
          if (phase_end) begin
            cnt_nx = '0;
            cw_nx  = 1'b0;
            ccw_nx = 1'b0;
            if (Location == goal) begin
              busy_nx    = 1'b0;
              done_nx    = 1'b1;
              clamped_nx = clamp;
              state_nx   = IDLE;
            end else begin
              state_nx = MOVE_LO;
`ifdef AXIS_RAMP_EN
              // Decelerate once the remaining distance fits the ramp-down, else accelerate.
              if (32'(rem) <= (32'(RAMP_START) - 32'(half))) begin
                half_nx = (half < START_HALF) ? (half + DIV_W'(1)) : START_HALF;
              end else if (half > DIV_W'(STEP_DIV)) begin
                half_nx = half - DIV_W'(1);
              end else begin
                half_nx = half;
              end
`endif
            end
          end else begin
            state_nx = MOVE_HI;
          end
        end
        HOME_LO: begin
          if (phase_end && ls_s) begin
            cnt_nx   = '0;
            loc_nx   = '0;
            homed_nx = 1'b1;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else if (phase_end) begin
            cnt_nx   = '0;
            ccw_nx   = 1'b1;
            loc_nx   = Location - POS_W'(1);
            state_nx = HOME_HI;
          end else begin
            state_nx = HOME_LO;
          end
        end
        HOME_HI: begin
          if (phase_end) begin
            cnt_nx   = '0;
            ccw_nx   = 1'b0;
            state_nx = HOME_LO;
          end else begin
            state_nx = HOME_HI;
          end
        end
        default: begin
          cnt_nx   = '0;
          cw_nx    = 1'b0;
          ccw_nx   = 1'b0;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_step_seeker.sv
// Self-checking bench for axis_step_seeker: expected step waveforms are built from the
// half-period schedule of each move and compared cycle by cycle.
module tb_axis_step_seeker;
  localparam int POS_W      = 19;
  localparam int DIV_W      = 16;
  localparam int STEP_DIV   = 4;
  localparam int HOME_DIV   = 8;
  localparam int RAMP_START = 32;
`ifdef AXIS_RAMP_EN
  localparam int FIRST_HALF = RAMP_START;
`else
  localparam int FIRST_HALF = STEP_DIV;
`endif

  logic             Clock = 1'b0;
  logic             Reset, Start, Home, LS, Abort;
  logic [POS_W-1:0] Target, Limit, Location;
  logic             CW, CCW, Busy, Done, Clamped, Err, Homed;

  int vectors = 0;
  int errors  = 0;
  int model_loc = 0;

  typedef struct {
    bit cw, ccw, busy, done, clamped;
    int loc;
  } exp_t;
  exp_t exp_q[$];

  always #5 Clock = ~Clock;

  axis_step_seeker #(
    .POS_W(POS_W), .DIV_W(DIV_W), .STEP_DIV(STEP_DIV), .HOME_DIV(HOME_DIV), .RAMP_START(RAMP_START)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Target(Target), .Limit(Limit),
    .Home(Home), .LS(LS), .Abort(Abort), .Location(Location), .CW(CW), .CCW(CCW),
    .Busy(Busy), .Done(Done), .Clamped(Clamped), .Err(Err), .Homed(Homed)
  );

  always @(negedge Clock) begin
    if (CW === 1'b1 && CCW === 1'b1) begin
      errors++;
      $display("FAIL cw_ccw_exclusive: both high at %0t, required at most one", $time);
    end
  end

  // Expected per-cycle outputs of a move, starting with the cycle after Start is accepted.
  function automatic void build_move(input int from, input int goal, input bit clamp);
    int p, loc;
    bit up;
    exp_q.delete();
    up  = goal > from;
    loc = from;
    p   = FIRST_HALF;
    while (loc != goal) begin
      repeat (p) exp_q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, loc});
      loc = up ? loc + 1 : loc - 1;
      repeat (p) exp_q.push_back('{up, !up, 1'b1, 1'b0, 1'b0, loc});
`ifdef AXIS_RAMP_EN
      begin
        int r;
        r = up ? goal - loc : loc - goal;
        if (r <= RAMP_START - p) p = (p + 1 > RAMP_START) ? RAMP_START : p + 1;
        else if (p > STEP_DIV) p = p - 1;
      end
`endif
    end
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, clamp, loc});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, loc});
  endfunction

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Home = 1'b0; LS = 1'b0; Abort = 1'b0;
    Target = '0; Limit = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    vectors++;
    if ({Location, CW, CCW, Busy, Done, Clamped, Err, Homed} !== {POS_W'(0), 7'b0}) begin
      errors++;
      $display("FAIL reset: got loc=%0d flags=%b, required 0 and 0000000",
               Location, {CW, CCW, Busy, Done, Clamped, Err, Homed});
    end
    Reset = 1'b0;
    model_loc = 0;
  endtask

  task automatic test_err_unhomed();
    @(negedge Clock);
    Target = POS_W'(5); Limit = POS_W'(100); Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clock);
      vectors++;
      if ({Err, Busy, Done, CW, CCW} !== {(k == 1), 4'b0000} || Location !== POS_W'(0)) begin
        errors++;
        $display("FAIL err_unhomed k=%0d: got err/busy/done/cw/ccw=%b loc=%0d, required %b loc=0",
                 k, {Err, Busy, Done, CW, CCW}, Location, {(k == 1), 4'b0000});
      end
    end
  endtask

  // Home with the switch already made; optionally Start in the same cycle (must be dropped).
  task automatic test_home(input bit with_start);
    LS = 1'b1;
    repeat (3) @(negedge Clock);
    Home = 1'b1; Start = with_start; Target = POS_W'(7); Limit = POS_W'(100);
    @(posedge Clock); #1 Home = 1'b0; Start = 1'b0;
    for (int k = 1; k <= HOME_DIV + 1; k++) begin
      @(negedge Clock);
      vectors++;
      if (k <= HOME_DIV) begin
        if ({CW, CCW, Busy, Done, Err, Homed} !== 6'b001000) begin
          errors++;
          $display("FAIL home_wait k=%0d: got cw/ccw/busy/done/err/homed=%b, required 001000",
                   k, {CW, CCW, Busy, Done, Err, Homed});
        end
      end else if ({CW, CCW, Busy, Done, Err, Homed} !== 6'b000101 || Location !== POS_W'(0)) begin
        errors++;
        $display("FAIL home_done: got flags=%b loc=%0d, required 000101 loc=0",
                 {CW, CCW, Busy, Done, Err, Homed}, Location);
      end
    end
    model_loc = 0;
    LS = 1'b0;
  endtask

  // Homing search from a small position with LS low: Location wraps below zero.
  task automatic test_home_search();
    logic [POS_W-1:0] exp_loc;
    int pulses, last_rise;
    bit prev_ccw, seen_done;
    exp_loc = POS_W'(model_loc);
    pulses = 0; last_rise = 0; prev_ccw = 1'b0; seen_done = 1'b0;
    LS = 1'b0;
    repeat (3) @(negedge Clock);
    Home = 1'b1;
    @(posedge Clock); #1 Home = 1'b0;
    for (int k = 1; k <= 2000 && !seen_done; k++) begin
      @(negedge Clock);
      if (CW !== 1'b0) begin
        errors++;
        $display("FAIL home_search_cw k=%0d: got CW=%b, required 0", k, CW);
      end
      if (CCW === 1'b1 && !prev_ccw) begin
        pulses++;
        exp_loc = exp_loc - 1'b1;
        vectors++;
        if (Location !== exp_loc || (k - last_rise) !== ((pulses == 1) ? HOME_DIV + 1 : 2 * HOME_DIV)) begin
          errors++;
          $display("FAIL home_search_step %0d: got loc=%0d spacing=%0d, required loc=%0d spacing=%0d",
                   pulses, Location, k - last_rise, exp_loc,
                   (pulses == 1) ? HOME_DIV + 1 : 2 * HOME_DIV);
        end
        last_rise = k;
        if (pulses == 5) LS = 1'b1;
      end
      prev_ccw = (CCW === 1'b1);
      seen_done = (Done === 1'b1);
    end
    vectors++;
    if (!seen_done || pulses != 5 || Location !== POS_W'(0) || Homed !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL home_search_end: got done=%0d pulses=%0d loc=%0d homed=%b busy=%b, required 1 5 0 1 0",
               seen_done, pulses, Location, Homed, Busy);
    end
    model_loc = 0;
    LS = 1'b0;
  endtask

  // Move to tgt under lim; abort_after>0 aborts on that pulse's rise; poke retries Start/Home mid-move.
  task automatic test_move(input int tgt, input int lim, input int abort_after, input bit poke);
    int goal, pulses;
    bit clamp, prev_hi, hi;
    exp_t e;
    clamp = tgt > lim;
    goal  = clamp ? lim : tgt;
    build_move(model_loc, goal, clamp);
    pulses = 0; prev_hi = 1'b0;
    @(negedge Clock);
    Target = POS_W'(tgt); Limit = POS_W'(lim); Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0; Target = POS_W'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge Clock);
      e = exp_q[k];
      vectors++;
      if ({CW, CCW, Busy, Done, Clamped, Location} !==
          {e.cw, e.ccw, e.busy, e.done, e.clamped, POS_W'(e.loc)}) begin
        errors++;
        $display("FAIL move %0d->%0d cycle %0d: got cw/ccw/busy/done/clamped=%b loc=%0d, required %b loc=%0d",
                 model_loc, goal, k + 1, {CW, CCW, Busy, Done, Clamped}, Location,
                 {e.cw, e.ccw, e.busy, e.done, e.clamped}, e.loc);
      end
      hi = e.cw | e.ccw;
      if (hi && !prev_hi) pulses++;
      prev_hi = hi;
      if (abort_after > 0 && pulses == abort_after && hi) begin
        Abort = 1'b1;
        @(posedge Clock); #1 Abort = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge Clock);
          vectors++;
          if ({CW, CCW, Busy, Done, Clamped} !== 5'b00000 || Location !== POS_W'(e.loc)) begin
            errors++;
            $display("FAIL abort cycle %0d: got flags=%b loc=%0d, required 00000 loc=%0d",
                     j + 1, {CW, CCW, Busy, Done, Clamped}, Location, e.loc);
          end
        end
        model_loc = e.loc;
        return;
      end
      if (poke && k == 2) begin
        Start = 1'b1; Home = 1'b1; Target = POS_W'(model_loc);
        @(posedge Clock); #1 Start = 1'b0; Home = 1'b0;
      end
    end
    model_loc = goal;
  endtask

  initial begin
    test_reset();
    test_err_unhomed();
    test_home(1'b0);
    test_move(10, 100, 0, 1'b0);
    test_move(3, 100, 0, 1'b1);
    test_move(3, 100, 0, 1'b0);
    test_move(200, 50, 0, 1'b0);
    test_move(80, 50, 0, 1'b0);
    test_move(60, 1000, 4, 1'b0);
    test_move(20, 19, 0, 1'b0);
    test_home(1'b1);
    for (int i = 0; i < 6; i++) begin
      test_move($urandom_range(0, 250), $urandom_range(0, 300), 0, (i % 2) == 1);
    end
    test_move(3, 100, 0, 1'b0);
    test_home_search();
    test_move(7, 7, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
